// File: rtl/multi_blink_pkg.sv
// Shared mode encoding and prescaler sizing helpers for the multi-channel LED blinker.
package multi_blink_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_OFF     = 2'd0;
  localparam mode_t MODE_SOLID   = 2'd1;
  localparam mode_t MODE_BLINK   = 2'd2;
  localparam mode_t MODE_ONESHOT = 2'd3;

  // Number of CLK cycles per TICK.
  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  // Prescaler counter width able to hold 0..div-1.
  function automatic int calc_div_w(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/blink_channel.sv
// One LED channel: latched mode/period/on-time, tick-driven phase, registered LED and DONE.
module blink_channel
  import multi_blink_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             wr,
  input  logic [1:0]       wr_mode,
  input  logic [CNT_W-1:0] wr_period,
  input  logic [CNT_W-1:0] wr_on,
  output logic             led,
  output logic             done
);

  mode_t            mode, mode_n;
  logic [CNT_W-1:0] period, period_n;
  logic [CNT_W-1:0] on_ticks, on_ticks_n;
  logic [CNT_W-1:0] ph, ph_n;
  logic             led_n;
  logic             done_n;
  logic             running;
  logic             last_phase;

  assign running    = (mode == MODE_BLINK) || (mode == MODE_ONESHOT);
  assign last_phase = (ph == period - CNT_W'(1));

  // NOTE: every variable gets its hold value first so no path through this block infers a latch.
  always_comb begin
    mode_n     = mode;
    period_n   = period;
    on_ticks_n = on_ticks;
    ph_n       = ph;
    done_n     = 1'b0;

    // A write on the same edge as a TICK wins: the tick is dropped for this channel.
    if (wr) begin
      mode_n     = mode_t'(wr_mode);
      period_n   = wr_period;
      on_ticks_n = wr_on;
      ph_n       = '0;
    end else if (tick && running) begin
      if (period == '0) begin
        // Degenerate period: blink just holds, a one-shot finishes immediately.
        if (mode == MODE_ONESHOT) begin
          mode_n = MODE_OFF;
          done_n = 1'b1;
        end
      end else if (last_phase) begin
        ph_n = '0;
        if (mode == MODE_ONESHOT) begin
          mode_n = MODE_OFF;
          done_n = 1'b1;
        end
      end else begin
        ph_n = ph + CNT_W'(1);
      end
    end

    // LED is derived from next state so a write or tick is visible right after its edge.
    unique case (mode_n)
      MODE_SOLID:                led_n = 1'b1;
      MODE_BLINK, MODE_ONESHOT:  led_n = (period_n != '0) && (ph_n < on_ticks_n);
      default:                   led_n = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode     <= MODE_OFF;
      period   <= '0;
      on_ticks <= '0;
      ph       <= '0;
      led      <= 1'b0;
      done     <= 1'b0;
    end else begin
      mode     <= mode_n;
      period   <= period_n;
      on_ticks <= on_ticks_n;
      ph       <= ph_n;
      led      <= led_n;
      done     <= done_n;
    end
  end

endmodule

// File: rtl/multi_blink_divider.sv
// LED timing generator: shared TICK prescaler plus CHANNELS independent blink_channel instances.
module multi_blink_divider
  import multi_blink_pkg::*;
#(
  parameter  int CLK_HZ   = 12_000_000,
  parameter  int TICK_HZ  = 1000,
  parameter  int CHANNELS = 3,
  parameter  int CNT_W    = 16,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [CH_W-1:0]     wr_ch,
  input  logic [CNT_W-1:0]    wr_period,
  input  logic [CNT_W-1:0]    wr_on,
  input  logic [1:0]          wr_mode,
  output logic                tick,
  output logic [CHANNELS-1:0] led,
  output logic [CHANNELS-1:0] done
);

  localparam int DIV     = calc_div(CLK_HZ, TICK_HZ);
  localparam int PRESC_W = calc_div_w(DIV);

  if ((CLK_HZ % TICK_HZ) != 0 || DIV < 2) begin : g_bad_div
    $error("multi_blink_divider: CLK_HZ must be a multiple of TICK_HZ with DIV >= 2");
  end
  if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
    $error("multi_blink_divider: CHANNELS must be in 1..16");
  end

  logic [PRESC_W-1:0] presc;
  logic               presc_last;

  assign presc_last = (presc == PRESC_W'(DIV - 1));

  // TICK is registered from the wrap condition, so it is high exactly one cycle in DIV.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      tick  <= 1'b0;
    end else begin
      presc <= presc_last ? '0 : presc + PRESC_W'(1);
      tick  <= presc_last;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    // Out-of-range channel numbers never match any instance, so such writes are dropped.
    logic wr_sel;
    assign wr_sel = wr_en && (wr_ch == CH_W'(g));

    blink_channel #(
      .CNT_W(CNT_W)
    ) u_channel (
      .clk      (clk),
      .rst      (rst),
      .tick     (tick),
      .wr       (wr_sel),
      .wr_mode  (wr_mode),
      .wr_period(wr_period),
      .wr_on    (wr_on),
      .led      (led[g]),
      .done     (done[g])
    );
  end

endmodule

// File: tb/tb_multi_blink_divider.sv
// Randomized and directed bench for multi_blink_divider against a tick-count reference model.
module tb_multi_blink_divider;

  localparam int CLK_HZ   = 100;
  localparam int TICK_HZ  = 10;
  localparam int DIV      = CLK_HZ / TICK_HZ;
  localparam int CHANNELS = 3;
  localparam int CNT_W    = 8;

  logic             clk;
  logic             rst;
  logic             wr_en;
  logic [1:0]       wr_ch;
  logic [CNT_W-1:0] wr_period;
  logic [CNT_W-1:0] wr_on;
  logic [1:0]       wr_mode;
  logic             tick;
  logic [2:0]       led;
  logic [2:0]       done;

  multi_blink_divider #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ),
    .CHANNELS(CHANNELS),
    .CNT_W   (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_ch    (wr_ch),
    .wr_period(wr_period),
    .wr_on    (wr_on),
    .wr_mode  (wr_mode),
    .tick     (tick),
    .led      (led),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: each channel remembers its config and how many ticks it has
  // seen since its last write; LED and DONE follow from that count arithmetically.
  int         m_mode [CHANNELS];
  int         m_per  [CHANNELS];
  int         m_on   [CHANNELS];
  int         m_nt   [CHANNELS];
  int         edges;
  logic       exp_tick;
  logic [2:0] exp_led;
  logic [2:0] exp_done;

  function automatic void model_reset();
    for (int c = 0; c < CHANNELS; c++) begin
      m_mode[c] = 0; m_per[c] = 0; m_on[c] = 0; m_nt[c] = 0;
    end
    edges    = 0;
    exp_tick = 1'b0;
    exp_led  = '0;
    exp_done = '0;
  endfunction

  function automatic void model_edge(input logic we, input int ch, input int md,
                                     input int per, input int ont);
    logic tick_in;
    tick_in  = exp_tick;
    edges++;
    exp_tick = (edges % DIV == 0);
    exp_done = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (we && ch == c) begin
        m_mode[c] = md; m_per[c] = per; m_on[c] = ont; m_nt[c] = 0;
      end else if (tick_in) begin
        if (m_mode[c] == 2 && m_per[c] != 0) begin
          m_nt[c]++;
        end else if (m_mode[c] == 3) begin
          m_nt[c]++;
          if (m_nt[c] >= ((m_per[c] == 0) ? 1 : m_per[c])) begin
            m_mode[c]   = 0;
            m_nt[c]     = 0;
            exp_done[c] = 1'b1;
          end
        end
      end
      case (m_mode[c])
        1:       exp_led[c] = 1'b1;
        2:       exp_led[c] = (m_per[c] != 0) && ((m_nt[c] % m_per[c]) < m_on[c]);
        3:       exp_led[c] = (m_per[c] != 0) && (m_nt[c] < m_on[c]);
        default: exp_led[c] = 1'b0;
      endcase
    end
  endfunction

  task automatic step(input logic we, input int ch, input int md, input int per, input int ont);
    wr_en     = we;
    wr_ch     = ch[1:0];
    wr_mode   = md[1:0];
    wr_period = per[CNT_W-1:0];
    wr_on     = ont[CNT_W-1:0];
    @(posedge clk);
    model_edge(we, ch, md, per, ont);
    #1;
    check("tick", {31'd0, tick}, {31'd0, exp_tick});
    check("led", {29'd0, led}, {29'd0, exp_led});
    check("done", {29'd0, done}, {29'd0, exp_done});
    wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, 0);
  endtask

  // Advance until the next edge carries a TICK into the channels.
  task automatic align_to_tick();
    for (int i = 0; i < DIV && !exp_tick; i++) step(1'b0, 0, 0, 0, 0);
  endtask

  // Called just after a sampling point: asserts reset between edges and checks outputs
  // drop before the next clock edge, then releases on a falling edge.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_async_led", {29'd0, led}, 32'd0);
    check("rst_async_done", {29'd0, done}, 32'd0);
    check("rst_async_tick", {31'd0, tick}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int cnt_tick, cnt_led, cnt_done;
    rst = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_mode = '0; wr_period = '0; wr_on = '0;
    #1 rst = 1'b1;
    #1;
    check("reset_led", {29'd0, led}, 32'd0);
    check("reset_done", {29'd0, done}, 32'd0);
    check("reset_tick", {31'd0, tick}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    model_reset();

    // Prescaler: 100 cycles hold exactly 10 single-cycle pulses.
    cnt_tick = 0;
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 0, 0, 0, 0);
      if (tick === 1'b1) cnt_tick++;
    end
    check("tick_count_100", cnt_tick, 10);

    // Blink ch1 period 4 on 1, written on a tick edge: 10 high of every 40.
    align_to_tick();
    step(1'b1, 1, 2, 4, 1);
    cnt_led = (led[1] === 1'b1) ? 1 : 0;
    for (int i = 1; i < 40; i++) begin
      step(1'b0, 0, 0, 0, 0);
      if (led[1] === 1'b1) cnt_led++;
    end
    check("blink_high_cycles", cnt_led, 10);

    // One-shot ch2 period 3 on 2: 20 high, then off, exactly one DONE.
    align_to_tick();
    step(1'b1, 2, 3, 3, 2);
    cnt_led  = (led[2] === 1'b1) ? 1 : 0;
    cnt_done = 0;
    for (int i = 1; i < 60; i++) begin
      step(1'b0, 0, 0, 0, 0);
      if (led[2] === 1'b1) cnt_led++;
      if (done[2] === 1'b1) cnt_done++;
    end
    check("oneshot_high_cycles", cnt_led, 20);
    check("oneshot_done_pulses", cnt_done, 1);

    // Boundaries: on >= period, period 0 blink, period 0 one-shot, out-of-range channel.
    step(1'b1, 0, 2, 4, 5);
    idle(45);
    step(1'b1, 0, 2, 0, 3);
    idle(25);
    step(1'b1, 0, 3, 0, 3);
    idle(25);
    step(1'b1, 3, 1, 7, 7);
    idle(15);

    // Write on a tick edge restarts the phase without a skipped tick.
    step(1'b1, 0, 2, 3, 1);
    idle(4);
    align_to_tick();
    step(1'b1, 0, 2, 3, 1);
    idle(35);

    // Independence: ch1/ch2 stay put while ch0 is rewritten.
    step(1'b1, 0, 2, 2, 1);
    step(1'b1, 1, 1, 0, 0);
    step(1'b1, 2, 0, 0, 0);
    idle(30);
    step(1'b1, 0, 3, 5, 2);
    idle(60);

    // Reset mid-pattern, then first tick lands in cycle DIV with all channels off.
    step(1'b1, 0, 2, 2, 1);
    idle(7);
    async_reset();
    idle(25);

    // Randomized traffic including out-of-range channels and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        async_reset();
      end else if ($urandom_range(0, 7) == 0) begin
        step(1'b1, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 6)), int'($urandom_range(0, 7)));
      end else begin
        step(1'b0, 0, 0, 0, 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
